// File: rtl/key_press_arbiter_if.sv
// Keypad arbiter bus: raw buttons in, one clean key event (or a multi-key abort) out.
interface key_press_arbiter_if #(
    parameter int NUM_KEYS = 4,
    parameter int CODE_W   = 2
);
    logic [NUM_KEYS-1:0] key_raw;
    logic                key_valid;
    logic [CODE_W-1:0]   key_code;
    logic                key_busy;
    logic                multi_err;

    modport master (output key_raw, input key_valid, key_code, key_busy, multi_err);
    modport slave  (input key_raw, output key_valid, key_code, key_busy, multi_err);
endinterface

// File: rtl/key_press_arbiter.sv
// Shared-sampler keypad conditioner: synchronizer, tick divider, debounce counter and a
// press/release FSM that emits one key event per physical press.
module key_press_arbiter #(
    parameter int NUM_KEYS  = 4,
    parameter int CODE_W    = 2,
    parameter int TICK_DIV  = 16,
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    key_press_arbiter_if.slave bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, RELEASE} state_t;

    logic [NUM_KEYS-1:0] sync1_reg, sync2_reg;
    logic [TW-1:0]       tick_cnt_reg;
    state_t              state_reg, state_next;
    logic [CW-1:0]       count_reg, count_next;
    logic [CODE_W-1:0]   cand_reg, cand_next;
    logic [CODE_W-1:0]   code_reg, code_next;
    logic                valid_reg, valid_next;
    logic                err_reg, err_next;
    logic                busy_reg, busy_next;

    logic [NUM_KEYS-1:0] key_s;
    logic                tick;
    logic                any_key;
    logic                multi_key;
    logic                cand_hit;
    logic [CODE_W-1:0]   low_idx;
    logic [CW-1:0]       count_inc;
    logic                count_done;

    assign key_s      = sync2_reg;
    assign tick       = (tick_cnt_reg == TW'(TICK_DIV - 1));
    assign any_key    = |key_s;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_key  = |(key_s & (key_s - NUM_KEYS'(1)));
    assign cand_hit   = key_s[cand_reg];
    assign count_inc  = count_reg + CW'(1);
    assign count_done = (count_inc == CW'(DB_CYCLES));

    always_comb begin
        low_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_s[i]) low_idx = CODE_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            tick_cnt_reg <= '0;
        end else begin
            sync1_reg    <= bus.key_raw;
            sync2_reg    <= sync1_reg;
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            cand_reg  <= '0;
            code_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            cand_reg  <= cand_next;
            code_reg  <= code_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        cand_next  = cand_reg;
        case (state_reg)
            IDLE: begin
                if (any_key) begin
                    cand_next  = low_idx;
                    count_next = '0;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (multi_key) begin
                        count_next = '0;
                        state_next = RELEASE;
                    end else if (!cand_hit) begin
                        state_next = IDLE;
                    end else if (count_done) begin
                        count_next = '0;
                        state_next = RELEASE;
                    end else begin
                        count_next = count_inc;
                    end
                end
            end
            RELEASE: begin
                // Any key held (including a newly pressed one) restarts the release count.
                if (tick) begin
                    if (any_key) begin
                        count_next = '0;
                    end else if (count_done) begin
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        count_next = count_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        valid_next = 1'b0;
        err_next   = 1'b0;
        code_next  = code_reg;
        busy_next  = (state_next != IDLE);
        if (state_reg == DEBOUNCE && tick) begin
            if (multi_key) begin
                err_next = 1'b1;
            end else if (cand_hit && count_done) begin
                valid_next = 1'b1;
                code_next  = cand_reg;
            end
        end
    end

    assign bus.key_valid = valid_reg;
    assign bus.key_code  = code_reg;
    assign bus.key_busy  = busy_reg;
    assign bus.multi_err = err_reg;
endmodule

// File: doc/key_press_arbiter.md
Name: key_press_arbiter

Overview:
- Conditions and arbitrates the lock's raw keypad buttons. Produces one clean, single-cycle key event per physical press.
- Sits between the board push-buttons and the combination-checking FSM.
- Replaces per-button shift-register debouncing with one shared sampler: a tick divider, a debounce counter and a press/release state machine.
- Rejects bounce, simultaneous presses and auto-repeat.

Parameters:
- NUM_KEYS, 4, number of raw key inputs (>=2).
- CODE_W, 2, width of key_code; must satisfy 2**CODE_W >= NUM_KEYS.
- TICK_DIV, 16, clock cycles per sample tick (>=1; 1 = sample every cycle).
- DB_CYCLES, 4, consecutive qualifying sample ticks required for press accept and for release accept (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- key_raw  input  NUM_KEYS  asynchronous raw buttons, active-high, bit i = key i.
- key_valid  output  1  one-cycle pulse: accepted press.
- key_code  output  CODE_W  index of accepted key; valid when key_valid=1, holds last value otherwise.
- key_busy  output  1  high whenever the FSM is not IDLE.
- multi_err  output  1  one-cycle pulse: press aborted because >1 key was seen.

Behaviour:
- Reset (reset=0, asynchronous):
  - key_valid=0, key_code=0, key_busy=0, multi_err=0.
  - Synchronizer flops=0, tick counter=0, debounce count=0, candidate=0, state=IDLE.
  - Reset asserted mid-operation aborts any press in progress; no pulse is emitted.
- Synchronizer: two flops per bit, key_s = key_raw delayed 2 cycles. All logic below uses key_s only.
- Tick counter: free-running 0..TICK_DIV-1, wraps to 0. tick=1 in the cycle the counter equals TICK_DIV-1.
- States: IDLE, DEBOUNCE, RELEASE.
- IDLE:
  - Any key_s bit set: candidate <= lowest set index, count <= 0, go DEBOUNCE.
  - No tick is required to leave IDLE.
- DEBOUNCE (evaluated only on tick cycles):
  - More than one key_s bit set: multi_err pulses next cycle, count <= 0, go RELEASE. Checked first.
  - Else candidate bit low: bounce rejected, no output, go IDLE.
  - Else count <= count+1. If count+1 == DB_CYCLES: key_code <= candidate, key_valid pulses next cycle, count <= 0, go RELEASE.
- RELEASE (evaluated only on tick cycles):
  - Any key_s bit set: count <= 0.
  - Else count <= count+1. If count+1 == DB_CYCLES, go IDLE.
  - A held key never re-triggers: exactly one key_valid per press regardless of hold time.
- Outputs are registered.
  - key_valid and multi_err are high for exactly one clk cycle, never both in the same cycle.
  - key_busy = (state != IDLE), registered with the state.
- Latency, steady press from IDLE: key_valid rises between 2+(DB_CYCLES-1)*TICK_DIV+2 and 2+DB_CYCLES*TICK_DIV+1 cycles after the key_raw edge, depending on tick phase.
- Debounce count width: clog2(DB_CYCLES+1); the count saturates by construction and never wraps.
- Simultaneous first edges in IDLE: the lowest index becomes candidate. The multi-key check on the first DEBOUNCE tick then aborts with multi_err.
- Second key pressed during RELEASE: ignored. It only restarts the release count.

Test Plan:
- TICK_DIV=4, DB_CYCLES=3; key_raw=4'b0100 held 100 cycles → exactly one key_valid pulse, key_code=2, rising within 2..15 cycles of the press. key_busy stays high until 3 ticks after release.
- Same settings; key 1 pulsed high for 5 cycles, then low (bounce) → no key_valid, FSM returns to IDLE (key_busy=0) after the first low tick.
- key_raw=4'b0011 applied in the same cycle → one multi_err pulse, no key_valid. FSM waits in RELEASE until all keys are low for 3 ticks.
- Key 3 held; key 0 pressed during RELEASE; both released → no additional key_valid. A later clean press of key 0 yields key_valid with key_code=0.
- reset driven low asynchronously mid-DEBOUNCE (between clk edges) → all outputs 0 immediately. After reset=1 with the key still held, a full new debounce runs and yields exactly one key_valid.
- TICK_DIV=1, DB_CYCLES=1; key 3 pressed → key_valid exactly 4 cycles after the key_raw edge, key_code=3.
